// File: rtl/conv32_8_if.sv
// conv32_8 bus bundle: 32-bit word input side and 8-bit byte output side.
// master = producer/consumer environment, slave = the converter.
interface conv32_8_if;
   logic [31:0] in_data32;
   logic        in32;
   logic        ready32;
   logic [7:0]  out_data8;
   logic        out8;
   logic        last8;
   logic        ready8;

   modport master (
      output in_data32, in32, ready8,
      input  ready32, out_data8, out8, last8
   );

   modport slave (
      input  in_data32, in32, ready8,
      output ready32, out_data8, out8, last8
   );
endinterface

// File: rtl/conv32_8.sv
// 32-to-8 width down-converter with a small word FIFO in front of a
// byte shift register; emits four bytes per word, last8 on the fourth.
module conv32_8 #(
   parameter int DEPTH     = 2,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic clk,
   input  logic reset,
   conv32_8_if.slave bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic {IDLE, SEND} state_t;

   state_t          state_q, state_d;
   logic [31:0]     mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [31:0]     sh_q, sh_d;
   logic [1:0]      idx_q, idx_d;
   logic [7:0]      out_data8_q, out_data8_d;
   logic            out8_q, out8_d;
   logic            last8_q, last8_d;
   logic            push, pop, xfer;
   logic [31:0]     head, nxt_sh;

   // Leading byte of a word in the configured emission order.
   function automatic logic [7:0] first_byte(input logic [31:0] w);
      return MSB_FIRST ? w[31:24] : w[7:0];
   endfunction

   // Accept only on registered occupancy; a same-cycle pop does not help.
   assign bus.ready32   = !reset && (count_q < CW'(DEPTH));
   assign push          = bus.in32 && bus.ready32;
   assign xfer          = out8_q && bus.ready8;
   assign head          = mem_q[rd_ptr_q];
   assign bus.out_data8 = out_data8_q;
   assign bus.out8      = out8_q;
   assign bus.last8     = last8_q;

   // Next-state, byte sequencing and FIFO bookkeeping.
   always_comb begin
      state_d     = state_q;
      sh_d        = sh_q;
      idx_d       = idx_q;
      out_data8_d = out_data8_q;
      out8_d      = out8_q;
      last8_d     = last8_q;
      pop         = 1'b0;
      nxt_sh      = MSB_FIRST ? (sh_q << 8) : (sh_q >> 8);
      unique case (state_q)
         IDLE: begin
            out8_d      = 1'b0;
            out_data8_d = 8'h00;
            last8_d     = 1'b0;
            if (count_q != '0) begin
               pop         = 1'b1;
               sh_d        = head;
               idx_d       = 2'd0;
               out8_d      = 1'b1;
               out_data8_d = first_byte(head);
               state_d     = SEND;
            end
         end
         SEND: begin
            if (xfer) begin
               if (idx_q == 2'd3) begin
                  last8_d = 1'b0;
                  if (count_q != '0) begin
                     pop         = 1'b1;
                     sh_d        = head;
                     idx_d       = 2'd0;
                     out_data8_d = first_byte(head);
                  end else begin
                     out8_d      = 1'b0;
                     out_data8_d = 8'h00;
                     state_d     = IDLE;
                  end
               end else begin
                  sh_d        = nxt_sh;
                  idx_d       = idx_q + 2'd1;
                  out_data8_d = first_byte(nxt_sh);
                  last8_d     = (idx_q == 2'd2);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   // State registers; reset discards buffered and in-flight words.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         sh_q        <= '0;
         idx_q       <= '0;
         out_data8_q <= 8'h00;
         out8_q      <= 1'b0;
         last8_q     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         sh_q        <= sh_d;
         idx_q       <= idx_d;
         out_data8_q <= out_data8_d;
         out8_q      <= out8_d;
         last8_q     <= last8_d;
         if (push) mem_q[wr_ptr_q] <= bus.in_data32;
      end
   end
endmodule

// File: tb/tb_conv32_8.sv
// Self-checking bench for conv32_8: directed scenarios on an MSB-first
// and an LSB-first instance, then a randomized run against a byte queue.
module tb_conv32_8;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   conv32_8_if bm ();
   conv32_8_if bl ();

   conv32_8 #(.DEPTH(2), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset(reset), .bus(bm)
   );
   conv32_8 #(.DEPTH(2), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .reset(reset), .bus(bl)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] byte_of(input logic [31:0] w,
                                          input int k, input bit msb);
      int sh;
      sh = msb ? (24 - 8 * k) : (8 * k);
      return 8'((w >> sh) & 32'hFF);
   endfunction

   task automatic idle_inputs();
      bm.in32 = 1'b0; bm.in_data32 = '0; bm.ready8 = 1'b1;
      bl.in32 = 1'b0; bl.in_data32 = '0; bl.ready8 = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      checks++;
      if (bm.out8 !== 1'b0 || bm.last8 !== 1'b0 || bm.out_data8 !== 8'h00) begin
         errors++;
         $display("FAIL reset_outs got v=%b l=%b d=%h want 0 0 00",
                  bm.out8, bm.last8, bm.out_data8);
      end
      checks++;
      if (bm.ready32 !== 1'b0 || bl.ready32 !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready32 got %b/%b want 0", bm.ready32, bl.ready32);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bm.ready32 !== 1'b1 || bm.out8 !== 1'b0 || bl.out8 !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got r=%b v=%b/%b want r=1 v=0",
                  bm.ready32, bm.out8, bl.out8);
      end
   endtask

   task automatic test_single();
      logic [31:0] w = 32'hA1B2C3D4;
      logic ev, el;
      logic [7:0] ed;
      int k;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         k  = c - 2;
         ev = (c >= 2 && c <= 5);
         ed = ev ? byte_of(w, k, 1'b1) : 8'h00;
         el = ev && (k == 3);
         checks++;
         if (bm.out8 !== ev || bm.out_data8 !== ed || bm.last8 !== el) begin
            errors++;
            $display("FAIL single c=%0d got v=%b d=%h l=%b want v=%b d=%h l=%b",
                     c, bm.out8, bm.out_data8, bm.last8, ev, ed, el);
         end
         bm.in32 = (c == 0); bm.in_data32 = w; bm.ready8 = 1'b1;
      end
      bm.in32 = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] w [2];
      logic ev, el;
      logic [7:0] ed;
      int k, wi;
      w[0] = 32'h11223344; w[1] = 32'h55667788; wi = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         k  = c - 2;
         ev = (c >= 2 && c <= 9);
         ed = ev ? byte_of(w[k/4], k % 4, 1'b1) : 8'h00;
         el = ev && (k % 4 == 3);
         checks++;
         if (bm.out8 !== ev || bm.out_data8 !== ed || bm.last8 !== el) begin
            errors++;
            $display("FAIL b2b c=%0d got v=%b d=%h l=%b want v=%b d=%h l=%b",
                     c, bm.out8, bm.out_data8, bm.last8, ev, ed, el);
         end
         checks++;
         if (bm.ready32 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready32 c=%0d got %b want 1", c, bm.ready32);
         end
         if (wi < 2 && bm.ready32) begin
            bm.in32 = 1'b1; bm.in_data32 = w[wi]; wi++;
         end else begin
            bm.in32 = 1'b0;
         end
         bm.ready8 = 1'b1;
      end
      bm.in32 = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [7:0] ed [12];
      logic ev [12];
      logic el;
      ed = '{8'h00, 8'h00, 8'hA1, 8'hB2, 8'hB2, 8'hB2, 8'hB2, 8'hB2,
             8'hB2, 8'hC3, 8'hD4, 8'h00};
      ev = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
             1'b1, 1'b1, 1'b1, 1'b0};
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         el = (c == 10);
         checks++;
         if (bm.out8 !== ev[c] || bm.out_data8 !== ed[c] || bm.last8 !== el) begin
            errors++;
            $display("FAIL backpressure c=%0d got v=%b d=%h l=%b want v=%b d=%h l=%b",
                     c, bm.out8, bm.out_data8, bm.last8, ev[c], ed[c], el);
         end
         bm.in32 = (c == 0); bm.in_data32 = 32'hA1B2C3D4;
         bm.ready8 = !(c >= 3 && c <= 7);
      end
      bm.in32 = 1'b0; bm.ready8 = 1'b1;
   endtask

   task automatic test_fill();
      logic [31:0] ws [3];
      logic ev, el, er;
      logic [7:0] ed;
      int k;
      ws[0] = 32'h01020304; ws[1] = 32'h05060708; ws[2] = 32'h090A0B0C;
      for (int c = 0; c < 19; c++) begin
         @(negedge clk);
         k = c - 5;
         if (c >= 2 && c <= 4) begin
            ev = 1'b1; ed = byte_of(ws[0], 0, 1'b1); el = 1'b0;
         end else if (c >= 5 && c <= 16) begin
            ev = 1'b1; ed = byte_of(ws[k/4], k % 4, 1'b1); el = (k % 4 == 3);
         end else begin
            ev = 1'b0; ed = 8'h00; el = 1'b0;
         end
         checks++;
         if (bm.out8 !== ev || bm.out_data8 !== ed || bm.last8 !== el) begin
            errors++;
            $display("FAIL fill c=%0d got v=%b d=%h l=%b want v=%b d=%h l=%b",
                     c, bm.out8, bm.out_data8, bm.last8, ev, ed, el);
         end
         if (c <= 4) begin
            er = (c <= 2);
            checks++;
            if (bm.ready32 !== er) begin
               errors++;
               $display("FAIL fill_ready32 c=%0d got %b want %b", c, bm.ready32, er);
            end
         end
         bm.ready8    = (c >= 5);
         bm.in32      = (c <= 4);
         bm.in_data32 = (c < 3) ? ws[c] : 32'hFFFFFFFF;
      end
      bm.in32 = 1'b0; bm.ready8 = 1'b1;
   endtask

   task automatic test_lsb_first();
      logic [31:0] w = 32'hA1B2C3D4;
      logic ev, el;
      logic [7:0] ed;
      int k;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         k  = c - 2;
         ev = (c >= 2 && c <= 5);
         ed = ev ? byte_of(w, k, 1'b0) : 8'h00;
         el = ev && (k == 3);
         checks++;
         if (bl.out8 !== ev || bl.out_data8 !== ed || bl.last8 !== el) begin
            errors++;
            $display("FAIL lsb c=%0d got v=%b d=%h l=%b want v=%b d=%h l=%b",
                     c, bl.out8, bl.out_data8, bl.last8, ev, ed, el);
         end
         bl.in32 = (c == 0); bl.in_data32 = w; bl.ready8 = 1'b1;
      end
      bl.in32 = 1'b0;
   endtask

   task automatic test_reset_mid_word();
      logic [31:0] w = 32'hDEADBEEF;
      logic ev, el;
      logic [7:0] ed;
      int k;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c >= 2) begin
            ed = (c == 2) ? 8'hA1 : 8'hB2;
            checks++;
            if (bm.out8 !== 1'b1 || bm.out_data8 !== ed) begin
               errors++;
               $display("FAIL rstmid_pre c=%0d got v=%b d=%h want v=1 d=%h",
                        c, bm.out8, bm.out_data8, ed);
            end
         end
         bm.in32      = (c <= 1);
         bm.in_data32 = (c == 0) ? 32'hA1B2C3D4 : 32'h99999999;
         bm.ready8    = 1'b1;
      end
      bm.in32 = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++;
      if (bm.out8 !== 1'b0 || bm.last8 !== 1'b0 || bm.out_data8 !== 8'h00 ||
          bm.ready32 !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_async got v=%b l=%b d=%h r=%b want 0 0 00 0",
                  bm.out8, bm.last8, bm.out_data8, bm.ready32);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         k  = c - 2;
         ev = (c >= 2 && c <= 5);
         ed = ev ? byte_of(w, k, 1'b1) : 8'h00;
         el = ev && (k == 3);
         checks++;
         if (bm.out8 !== ev || bm.out_data8 !== ed || bm.last8 !== el) begin
            errors++;
            $display("FAIL rstmid_post c=%0d got v=%b d=%h l=%b want v=%b d=%h l=%b",
                     c, bm.out8, bm.out_data8, bm.last8, ev, ed, el);
         end
         bm.in32 = (c == 0); bm.in_data32 = w; bm.ready8 = 1'b1;
      end
      bm.in32 = 1'b0;
   endtask

   task automatic test_random();
      logic [7:0]  mq [$];
      logic [31:0] w;
      logic [7:0]  pd;
      logic        pv, pl, pr, iv;
      int          sent;
      pv = 1'b0; pl = 1'b0; pr = 1'b1; pd = 8'h00; sent = 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (bm.out8) begin
            checks++;
            if (mq.size() == 0) begin
               errors++;
               $display("FAIL rnd_spurious c=%0d got d=%h want no byte", c, bm.out_data8);
            end else if (bm.out_data8 !== mq[0] || bm.last8 !== (sent % 4 == 3)) begin
               errors++;
               $display("FAIL rnd_byte c=%0d got d=%h l=%b want d=%h l=%b",
                        c, bm.out_data8, bm.last8, mq[0], (sent % 4 == 3));
            end
         end else begin
            checks++;
            if (bm.out_data8 !== 8'h00 || bm.last8 !== 1'b0) begin
               errors++;
               $display("FAIL rnd_idle c=%0d got d=%h l=%b want 00 0",
                        c, bm.out_data8, bm.last8);
            end
         end
         if (pv && !pr) begin
            checks++;
            if (bm.out8 !== 1'b1 || bm.out_data8 !== pd || bm.last8 !== pl) begin
               errors++;
               $display("FAIL rnd_hold c=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                        c, bm.out8, bm.out_data8, bm.last8, pd, pl);
            end
         end
         pv = bm.out8; pd = bm.out_data8; pl = bm.last8;
         pr = (c >= 500) ? 1'b1 : ($urandom_range(0, 3) != 0);
         bm.ready8 = pr;
         if (bm.out8 && pr && mq.size() > 0) begin
            void'(mq.pop_front());
            sent++;
         end
         iv = (c < 500) && ($urandom_range(0, 2) != 0);
         w  = $urandom;
         bm.in32 = iv; bm.in_data32 = w;
         if (iv && bm.ready32)
            for (int k = 0; k < 4; k++) mq.push_back(byte_of(w, k, 1'b1));
      end
      checks++;
      if (mq.size() != 0) begin
         errors++;
         $display("FAIL rnd_drain got %0d bytes left want 0", mq.size());
      end
      bm.in32 = 1'b0; bm.ready8 = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_fill();
      test_lsb_first();
      test_reset_mid_word();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
